// File: rtl/vec3_normalize_folded_pkg.sv
// Shared types and Q16.16 fixed-point helpers for the folded vec3 normaliser.
// Optional zero-vector guard is selected by the VEC3_NORM_ZERO_GUARD_EN macro (see top module).
package vec3_normalize_folded_pkg;

    localparam int FP_W    = 32;
    localparam int FP_FRAC = 16;

    typedef logic signed [FP_W-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQ,
        ST_ISSUE,
        ST_WAIT,
        ST_SCALE
    } vec3_norm_state_t;

    localparam fp_t FP_ZERO = '0;

    // Full-precision product, then drop the extra fraction bits (no saturation).
    function automatic fp_t fp_mul(fp_t a, fp_t b);
        logic signed [2*FP_W-1:0] p;
        p = (2*FP_W)'(a) * (2*FP_W)'(b);
        return p[FP_FRAC+FP_W-1:FP_FRAC];
    endfunction

    function automatic fp_t fp_add(fp_t a, fp_t b);
        return a + b;
    endfunction

    function automatic fp_t vec3_get(vec3_t v, logic [1:0] k);
        fp_t c;
        case (k)
            2'd0:    c = v.x;
            2'd1:    c = v.y;
            default: c = v.z;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vec3_normalize_folded_if.sv
// Request/result and inverse-sqrt handshake bundle for vec3_normalize_folded.
// slave = normaliser side, master = client / inverse-sqrt unit side.
interface vec3_normalize_folded_if;
    import vec3_normalize_folded_pkg::*;

    vec3_t v_in;
    logic  valid_in;
    vec3_t res_out;
    logic  valid_out;
    logic  ready_out;
    logic  err_out;
    fp_t   isq_a_out;
    logic  isq_valid_out;
    logic  isq_ready_in;
    fp_t   isq_res_in;
    logic  isq_valid_in;

    modport slave (
        input  v_in, valid_in, isq_ready_in, isq_res_in, isq_valid_in,
        output res_out, valid_out, ready_out, err_out, isq_a_out, isq_valid_out
    );

    modport master (
        output v_in, valid_in, isq_ready_in, isq_res_in, isq_valid_in,
        input  res_out, valid_out, ready_out, err_out, isq_a_out, isq_valid_out
    );
endinterface

// File: rtl/vec3_normalize_folded.sv
// Folded vec3 normaliser: one shared fp_mul for squares and scaling, external 1/sqrt over valid/ready.
// Define VEC3_NORM_ZERO_GUARD_EN to short-circuit zero vectors to an error result.
module vec3_normalize_folded
    import vec3_normalize_folded_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    vec3_normalize_folded_if.slave      bus
);

    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    vec3_norm_state_t state_reg, state_next;
    vec3_t            v_reg, v_next;
    vec3_t            res_reg, res_next;
    fp_t              acc_reg, acc_next;
    fp_t              r_reg, r_next;
    logic [1:0]       k_reg, k_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             valid_reg, valid_next;
    logic             err_reg, err_next;

    fp_t mul_a, mul_b, prod;

    // The single multiplier squares v[k] in SQ and scales v[k] by r in SCALE.
    always_comb begin
        mul_a = vec3_get(v_reg, k_reg);
        mul_b = (state_reg == ST_SQ) ? mul_a : r_reg;
        prod  = fp_mul(mul_a, mul_b);
    end

    always_comb begin
        state_next = state_reg;
        v_next     = v_reg;
        res_next   = res_reg;
        acc_next   = acc_reg;
        r_next     = r_reg;
        k_next     = k_reg;
        tmo_next   = tmo_reg;
        valid_next = valid_reg;
        err_next   = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    v_next     = bus.v_in;
                    valid_next = 1'b0;
                    err_next   = 1'b0;
                    k_next     = 2'd0;
                    state_next = ST_SQ;
                end
            end
            ST_SQ: begin
                acc_next = fp_add((k_reg == 2'd0) ? FP_ZERO : acc_reg, prod);
                if (k_reg == 2'd2) begin
                    k_next     = 2'd0;
                    state_next = ST_ISSUE;
`ifdef VEC3_NORM_ZERO_GUARD_EN
                    if (acc_next == FP_ZERO) begin
                        res_next   = '0;
                        err_next   = 1'b1;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end
`endif
                end else begin
                    k_next = k_reg + 2'd1;
                end
            end
            ST_ISSUE: begin
                if (bus.isq_ready_in) begin
                    tmo_next   = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Timeout wins over a result arriving on the same edge.
                if ((TIMEOUT_CYCLES > 0) && (tmo_reg == TMO_W'(TMO_LAST))) begin
                    res_next   = '0;
                    err_next   = 1'b1;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (bus.isq_valid_in) begin
                    r_next     = bus.isq_res_in;
                    k_next     = 2'd0;
                    state_next = ST_SCALE;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            ST_SCALE: begin
                case (k_reg)
                    2'd0:    res_next.x = prod;
                    2'd1:    res_next.y = prod;
                    default: res_next.z = prod;
                endcase
                if (k_reg == 2'd2) begin
                    k_next     = 2'd0;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    k_next = k_reg + 2'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
            v_reg     <= '0;
            res_reg   <= '0;
            acc_reg   <= FP_ZERO;
            r_reg     <= FP_ZERO;
            k_reg     <= 2'd0;
            tmo_reg   <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            v_reg     <= v_next;
            res_reg   <= res_next;
            acc_reg   <= acc_next;
            r_reg     <= r_next;
            k_reg     <= k_next;
            tmo_reg   <= tmo_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign bus.res_out       = res_reg;
    assign bus.valid_out     = valid_reg;
    assign bus.err_out       = err_reg;
    assign bus.ready_out     = (state_reg == ST_IDLE);
    assign bus.isq_valid_out = (state_reg == ST_ISSUE);
    assign bus.isq_a_out     = (state_reg == ST_ISSUE) ? acc_reg : FP_ZERO;

endmodule

// File: tb/tb_vec3_normalize_folded.sv
// Directed bench for vec3_normalize_folded with a behavioural inverse-sqrt responder (L = 10, level valid).
module tb_vec3_normalize_folded;
    import vec3_normalize_folded_pkg::*;

    localparam int L = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    int   req_cyc = 0;
    int   lat;
    int   isq_snap;

    // Responder controls (written only by the stimulus block)
    int   hold_req = 0;
    logic no_return = 1'b0;

    // Responder state (written only by the responder process)
    logic m_busy, m_valid;
    int   m_cnt, acc_cyc, stall_cnt, isq_cnt;
    fp_t  m_s, m_res;

    vec3_normalize_folded_if bus();

    vec3_normalize_folded #(.TIMEOUT_CYCLES(64)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic fp_t isq_model(fp_t s);
        real sr;
        if (s <= 0) return 32'sh7FFF_FFFF;
        sr = real'(s) / 65536.0;
        return fp_t'($rtoi(65536.0 / $sqrt(sr)));
    endfunction

    assign bus.isq_ready_in = !m_busy && !m_valid && (stall_cnt >= hold_req);
    assign bus.isq_valid_in = m_valid;
    assign bus.isq_res_in   = m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_s <= '0; m_res <= '0;
            acc_cyc <= 0; stall_cnt <= 0; isq_cnt <= 0;
        end else begin
            if (bus.isq_valid_out) isq_cnt <= isq_cnt + 1;
            if (bus.isq_valid_out && !bus.isq_ready_in && stall_cnt < hold_req)
                stall_cnt <= stall_cnt + 1;
            if (m_valid) m_valid <= 1'b0;
            if (bus.isq_valid_out && bus.isq_ready_in) begin
                m_busy  <= !no_return;
                m_cnt   <= 0;
                m_s     <= bus.isq_a_out;
                acc_cyc <= cyc + 1;
            end else if (m_busy) begin
                if (m_cnt == L - 2) begin
                    m_valid <= 1'b1;
                    m_busy  <= 1'b0;
                    m_res   <= isq_model(m_s);
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [95:0] v);
        int n = 0;
        while (!bus.ready_out && n < 100) begin tick(); n++; end
        bus.v_in     = v;
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        req_cyc      = cyc;
    endtask

    // Edges from the accept edge until valid_out, or -1 if it never came.
    task automatic wait_valid(output int l);
        while (!bus.valid_out && (cyc - req_cyc) < 300) tick();
        l = bus.valid_out ? cyc - req_cyc : -1;
    endtask

    initial begin
        bus.v_in     = '0;
        bus.valid_in = 1'b0;
        #1;
        check("rst_res",       96'(bus.res_out),       96'd0);
        check("rst_valid",     96'(bus.valid_out),     96'd0);
        check("rst_ready",     96'(bus.ready_out),     96'd1);
        check("rst_err",       96'(bus.err_out),       96'd0);
        check("rst_isq_valid", 96'(bus.isq_valid_out), 96'd0);
        check("rst_isq_a",     96'(bus.isq_a_out),     96'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: (3,4,0) -> s=25, r=0.2 (13107), res=(39321,52428,0)
        request({32'h0003_0000, 32'h0004_0000, 32'h0});
        check("t1_ready_busy", 96'(bus.ready_out), 96'd0);
        tick(); tick(); tick();
        check("t1_isq_valid", 96'(bus.isq_valid_out), 96'd1);
        check("t1_isq_a",     96'(bus.isq_a_out),     96'h0019_0000);
        wait_valid(lat);
        check("t1_latency", 96'(lat), 96'd17);
        check("t1_res",     96'(bus.res_out), {32'd39321, 32'd52428, 32'd0});
        check("t1_err",     96'(bus.err_out), 96'd0);
        check("t1_ready",   96'(bus.ready_out), 96'd1);

        // 2: back-to-back (1,0,0) then (-2,0,0); a request while busy is ignored
        request({32'h0001_0000, 32'h0, 32'h0});
        check("t2a_ready_busy", 96'(bus.ready_out), 96'd0);
        bus.v_in     = {32'h0005_0000, 32'h0005_0000, 32'h0005_0000};
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        wait_valid(lat);
        check("t2a_latency", 96'(lat), 96'd17);
        check("t2a_res",     96'(bus.res_out), {32'h0001_0000, 32'h0, 32'h0});
        request({32'hFFFE_0000, 32'h0, 32'h0});
        check("t2b_valid_clr", 96'(bus.valid_out), 96'd0);
        wait_valid(lat);
        check("t2b_latency", 96'(lat), 96'd17);
        check("t2b_res",     96'(bus.res_out), {32'hFFFF_0000, 32'h0, 32'h0});

        // 3: unit holds ready low 5 cycles; operand must stay stable, latency +5
        hold_req = 5;
        request({32'h0001_0000, 32'h0, 32'h0});
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_isq_valid_hold", 96'(bus.isq_valid_out), 96'd1);
            check("t3_isq_a_hold",     96'(bus.isq_a_out),     96'h0001_0000);
            tick();
        end
        wait_valid(lat);
        check("t3_latency", 96'(lat), 96'd22);
        check("t3_res",     96'(bus.res_out), {32'h0001_0000, 32'h0, 32'h0});
        hold_req = 0;

        // 4: zero vector
        isq_snap = isq_cnt;
        request(96'd0);
        wait_valid(lat);
        check("t4_res", 96'(bus.res_out), 96'd0);
`ifdef VEC3_NORM_ZERO_GUARD_EN
        check("t4_latency",  96'(lat), 96'd3);
        check("t4_err",      96'(bus.err_out), 96'd1);
        check("t4_isq_idle", 96'(isq_cnt - isq_snap), 96'd0);
`else
        check("t4_latency", 96'(lat), 96'd17);
        check("t4_err",     96'(bus.err_out), 96'd0);
        check("t4_issued",  96'(isq_cnt - isq_snap), 96'd1);
`endif

        // 5: unit never answers -> abort 64 edges after WAIT entry
        no_return = 1'b1;
        request({32'h0003_0000, 32'h0004_0000, 32'h0});
        wait_valid(lat);
        check("t5_wait_edges", 96'(cyc - acc_cyc), 96'd64);
        check("t5_err",        96'(bus.err_out), 96'd1);
        check("t5_valid",      96'(bus.valid_out), 96'd1);
        check("t5_res",        96'(bus.res_out), 96'd0);
        no_return = 1'b0;
        request({32'h0001_0000, 32'h0, 32'h0});
        check("t5_err_clr", 96'(bus.err_out), 96'd0);
        wait_valid(lat);
        check("t5_next_res", 96'(bus.res_out), {32'h0001_0000, 32'h0, 32'h0});

        // 6: async reset mid-SCALE, then (0,0,2) -> (0,0,1)
        request({32'h0003_0000, 32'h0004_0000, 32'h0});
        repeat (15) tick();
        check("t6_res_partial", 96'(bus.res_out.x), 96'd39321);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_res",       96'(bus.res_out),       96'd0);
        check("t6_rst_valid",     96'(bus.valid_out),     96'd0);
        check("t6_rst_ready",     96'(bus.ready_out),     96'd1);
        check("t6_rst_err",       96'(bus.err_out),       96'd0);
        check("t6_rst_isq_valid", 96'(bus.isq_valid_out), 96'd0);
        check("t6_rst_isq_a",     96'(bus.isq_a_out),     96'd0);
        rst = 1'b0;
        tick();
        request({32'h0, 32'h0, 32'h0002_0000});
        wait_valid(lat);
        check("t6_latency", 96'(lat), 96'd17);
        check("t6_res",     96'(bus.res_out), {32'h0, 32'h0, 32'h0001_0000});
        check("t6_err",     96'(bus.err_out), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
